// File: rtl/frame_stream_tx.sv
// frame_stream_tx: replays a stored frame from a synchronous-read RAM as a
// raster pixel stream (valid/data/sof/eol), with horizontal blanking between lines.
module frame_stream_tx #(
   parameter int DATA_WIDTH = 8,
   parameter int IMG_WIDTH  = 10,
   parameter int IMG_HEIGHT = 7,
   parameter int HBLANK     = 2,
   parameter int ADDR_WIDTH = 7
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_start,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_rd_en,
   output logic [ADDR_WIDTH-1:0] o_rd_addr,
   input  logic [DATA_WIDTH-1:0] i_rd_data,
   output logic                  o_valid_out,
   output logic [DATA_WIDTH-1:0] o_data_out,
   output logic                  o_eol_out,
   output logic                  o_sof_out
);

   localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
   localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
   localparam int BW = $clog2(HBLANK + 2);
   localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);
   localparam logic [BW-1:0] B_LAST = BW'((HBLANK > 0) ? HBLANK - 1 : 0);

   // S_DONE is a separate state so the o_done cycle still counts as busy
   // and ignores i_start.
   typedef enum logic [2:0] {S_IDLE, S_READ, S_BLANK, S_DRAIN, S_DONE} state_t;

   state_t                state, state_nx;
   logic [XW-1:0]         x, x_nx;
   logic [YW-1:0]         y, y_nx;
   logic [ADDR_WIDTH-1:0] addr, addr_nx;
   logic [BW-1:0]         bcnt, bcnt_nx;

   logic rd_en, rd_sof, rd_eol, busy, done;
   logic vld_p0, sof_p0, eol_p0;

   // Next-state logic: walk the raster, insert blanking, drain the pipeline.
   always_comb begin
      state_nx = state;
      x_nx     = x;
      y_nx     = y;
      addr_nx  = addr;
      bcnt_nx  = bcnt;
      case (state)
         S_IDLE: begin
            if (i_start) begin
               state_nx = S_READ;
               x_nx     = '0;
               y_nx     = '0;
               addr_nx  = '0;
            end
         end
         S_READ: begin
            if (x == X_LAST) begin
               x_nx = '0;
               if (y == Y_LAST) begin
                  state_nx = S_DRAIN;
               end else begin
                  y_nx     = y + 1'b1;
                  addr_nx  = addr + 1'b1;
                  bcnt_nx  = '0;
                  state_nx = (HBLANK == 0) ? S_READ : S_BLANK;
               end
            end else begin
               x_nx    = x + 1'b1;
               addr_nx = addr + 1'b1;
            end
         end
         S_BLANK: begin
            if (bcnt == B_LAST) state_nx = S_READ;
            else                bcnt_nx  = bcnt + 1'b1;
         end
         // last read has left stage p0 once vld_p0 drops; it is on the outputs now
         S_DRAIN: begin
            if (!vld_p0) state_nx = S_DONE;
         end
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // State register and raster counters.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= S_IDLE;
         x     <= '0;
         y     <= '0;
         addr  <= '0;
         bcnt  <= '0;
      end else begin
         state <= state_nx;
         x     <= x_nx;
         y     <= y_nx;
         addr  <= addr_nx;
         bcnt  <= bcnt_nx;
      end
   end

   // Read issue with its frame flags, plus registered busy/done status.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rd_en  <= 1'b0;
         rd_sof <= 1'b0;
         rd_eol <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         rd_en  <= (state_nx == S_READ);
         rd_sof <= (state_nx == S_READ) && (x_nx == '0) && (y_nx == '0);
         rd_eol <= (state_nx == S_READ) && (x_nx == X_LAST);
         busy   <= (state_nx != S_IDLE);
         done   <= (state_nx == S_DONE);
      end
   end

   // Stage p0: flags wait one cycle while the RAM produces the read data.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         vld_p0 <= 1'b0;
         sof_p0 <= 1'b0;
         eol_p0 <= 1'b0;
      end else begin
         vld_p0 <= rd_en;
         sof_p0 <= rd_sof;
         eol_p0 <= rd_eol;
      end
   end

   // Stage p1: register RAM data with aligned flags; foreign read data is never captured.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_valid_out <= 1'b0;
         o_sof_out   <= 1'b0;
         o_eol_out   <= 1'b0;
         o_data_out  <= '0;
      end else begin
         o_valid_out <= vld_p0;
         o_sof_out   <= sof_p0;
         o_eol_out   <= eol_p0;
         if (vld_p0) o_data_out <= i_rd_data;
      end
   end

   assign o_rd_en   = rd_en;
   assign o_rd_addr = addr;
   assign o_busy    = busy;
   assign o_done    = done;

endmodule

// File: tb/tb_frame_stream_tx.sv
// tb_frame_stream_tx: three frame_stream_tx configurations driven with directed and
// randomized start/reset stimulus, checked each cycle against a raster-timing model.
module tb_frame_stream_tx;

   localparam int CW [3] = '{10, 3, 1};
   localparam int CH [3] = '{7, 2, 4};
   localparam int CB [3] = '{2, 0, 1};

   typedef struct {
      int cyc;
      int data;
      bit eol;
      bit sof;
   } pix_t;

   logic            clk;
   logic [2:0]      rst_n, start, busy, done, rd_en, valid, eol, sof;
   logic [2:0][6:0] addr;
   logic [2:0][7:0] rd_data, data;
   logic [7:0]      mem [3][128];

   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;
   int   ks [3];
   bit   mact [3];
   int   done_cnt [3];
   int   done_cyc [3];
   pix_t obs0 [$];
   pix_t obs1 [$];
   pix_t obs2 [$];

   frame_stream_tx #(.DATA_WIDTH(8), .IMG_WIDTH(CW[0]), .IMG_HEIGHT(CH[0]), .HBLANK(CB[0]), .ADDR_WIDTH(7)) dut0 (
      .i_clk(clk), .i_rst_n(rst_n[0]), .i_start(start[0]), .o_busy(busy[0]), .o_done(done[0]),
      .o_rd_en(rd_en[0]), .o_rd_addr(addr[0]), .i_rd_data(rd_data[0]), .o_valid_out(valid[0]),
      .o_data_out(data[0]), .o_eol_out(eol[0]), .o_sof_out(sof[0]));

   frame_stream_tx #(.DATA_WIDTH(8), .IMG_WIDTH(CW[1]), .IMG_HEIGHT(CH[1]), .HBLANK(CB[1]), .ADDR_WIDTH(7)) dut1 (
      .i_clk(clk), .i_rst_n(rst_n[1]), .i_start(start[1]), .o_busy(busy[1]), .o_done(done[1]),
      .o_rd_en(rd_en[1]), .o_rd_addr(addr[1]), .i_rd_data(rd_data[1]), .o_valid_out(valid[1]),
      .o_data_out(data[1]), .o_eol_out(eol[1]), .o_sof_out(sof[1]));

   frame_stream_tx #(.DATA_WIDTH(8), .IMG_WIDTH(CW[2]), .IMG_HEIGHT(CH[2]), .HBLANK(CB[2]), .ADDR_WIDTH(7)) dut2 (
      .i_clk(clk), .i_rst_n(rst_n[2]), .i_start(start[2]), .o_busy(busy[2]), .o_done(done[2]),
      .o_rd_en(rd_en[2]), .o_rd_addr(addr[2]), .i_rd_data(rd_data[2]), .o_valid_out(valid[2]),
      .o_data_out(data[2]), .o_eol_out(eol[2]), .o_sof_out(sof[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // synchronous-read frame RAMs; non-read cycles present junk on the data bus
   always @(posedge clk) begin
      for (int d = 0; d < 3; d++)
         rd_data[d] <= rd_en[d] ? mem[d][addr[d]] : 8'($urandom);
   end

   task automatic check(input string nm, input int d, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         if (fails <= 40)
            $display("FAIL d%0d %s cyc=%0d got=0x%0h exp=0x%0h", d, nm, cyc, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input int d, output int k);
      start[d] = 1'b1;
      tick();
      k = cyc;
      start[d] = 1'b0;
   endtask

   task automatic wait_done(input int d, input int budget);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         tick();
         if (done[d] === 1'b1) seen = 1'b1;
      end
      check("done_seen", d, 32'(seen), 32'd1);
   endtask

   task automatic fill_random(input int d);
      for (int a = 0; a < 128; a++) mem[d][a] = 8'($urandom);
   endtask

   // Reference: a frame whose start is sampled at edge ks occupies cycles rel = n - ks.
   // Reads at rel t, outputs at rel t+2, for t in the valid window with line period W+HB.
   initial begin : compare
      int rel, v, per, win;
      bit e_busy, e_rd, e_vld, e_done;
      pix_t p;
      for (int d = 0; d < 3; d++) begin
         mact[d] = 1'b0; ks[d] = 0; done_cnt[d] = 0; done_cyc[d] = 0;
      end
      forever begin
         @(negedge clk);
         for (int d = 0; d < 3; d++) begin
            per = CW[d] + CB[d];
            win = CW[d] * CH[d] + (CH[d] - 1) * CB[d];
            if (rst_n[d] !== 1'b1) begin
               mact[d] = 1'b0;
               check("reset_outputs", d,
                     32'({busy[d], done[d], rd_en[d], valid[d], eol[d], sof[d], data[d]}), 32'd0);
            end else begin
               rel    = mact[d] ? cyc - ks[d] : -100;
               v      = rel - 2;
               e_busy = (rel >= 0) && (rel <= win + 2);
               e_rd   = (rel >= 0) && (rel < win) && ((rel % per) < CW[d]);
               e_vld  = (v >= 0) && (v < win) && ((v % per) < CW[d]);
               e_done = (rel == win + 2);
               check("busy", d, 32'(busy[d]), 32'(e_busy));
               check("done", d, 32'(done[d]), 32'(e_done));
               check("rd_en", d, 32'(rd_en[d]), 32'(e_rd));
               check("valid", d, 32'(valid[d]), 32'(e_vld));
               if (e_rd)
                  check("rd_addr", d, 32'(addr[d]), 32'((rel / per) * CW[d] + rel % per));
               if (e_vld) begin
                  check("data", d, 32'(data[d]), 32'(mem[d][(v / per) * CW[d] + v % per]));
                  check("eol", d, 32'(eol[d]), 32'((v % per) == CW[d] - 1));
                  check("sof", d, 32'(sof[d]), 32'(v == 0));
               end
               if (valid[d] === 1'b1) begin
                  p.cyc = cyc; p.data = int'(data[d]); p.eol = eol[d]; p.sof = sof[d];
                  case (d)
                     0: obs0.push_back(p);
                     1: obs1.push_back(p);
                     default: obs2.push_back(p);
                  endcase
               end
               if (done[d] === 1'b1) begin
                  done_cnt[d]++;
                  done_cyc[d] = cyc;
               end
               if (rel >= win + 2) mact[d] = 1'b0;
               if (!e_busy && start[d] === 1'b1) begin
                  ks[d]   = cyc + 1;
                  mact[d] = 1'b1;
               end
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int k, dc, d1, d2, idx, errs, d, budget;
      bit hold, ok;
      int eol_exp [7];
      eol_exp = '{9, 19, 29, 39, 49, 59, 69};
      rst_n = '0;
      start = '0;
      for (int dd = 0; dd < 3; dd++) fill_random(dd);
      repeat (3) tick();
      rst_n = '1;
      repeat (3) tick();

      // basic frame, RAM[a] = a
      for (int a = 0; a < 128; a++) mem[0][a] = 8'(a);
      obs0.delete();
      dc = done_cnt[0];
      pulse_start(0, k);
      wait_done(0, 200);
      tick();
      check("basic_npix", 0, obs0.size(), 70);
      if (obs0.size() == 70) begin
         check("basic_first_valid", 0, obs0[0].cyc - k, 2);
         check("basic_last_valid", 0, obs0[69].cyc - k, 83);
         check("basic_line_gap", 0, obs0[10].cyc - obs0[9].cyc, 3);
         errs = 0;
         idx = 0;
         for (int i = 0; i < 70; i++) begin
            if (obs0[i].data != i) errs++;
            if (obs0[i].sof != (i == 0)) errs++;
            if (obs0[i].eol) begin
               if (idx < 7) check("basic_eol_data", 0, obs0[i].data, eol_exp[idx]);
               idx++;
            end
         end
         check("basic_seq_errs", 0, errs, 0);
         check("basic_eol_count", 0, idx, 7);
      end
      check("basic_done_at", 0, done_cyc[0] - k, 84);
      check("basic_done_count", 0, done_cnt[0] - dc, 1);
      check("basic_busy_after", 0, 32'(busy[0]), 0);

      // no blanking, 3x2, RAM = 0xA0 + a
      for (int a = 0; a < 128; a++) mem[1][a] = 8'(8'hA0 + a);
      obs1.delete();
      pulse_start(1, k);
      wait_done(1, 50);
      tick();
      check("nob_npix", 1, obs1.size(), 6);
      if (obs1.size() == 6) begin
         check("nob_first_valid", 1, obs1[0].cyc - k, 2);
         check("nob_contiguous", 1, obs1[5].cyc - obs1[0].cyc, 5);
         for (int i = 0; i < 6; i++) begin
            check("nob_data", 1, obs1[i].data, 32'hA0 + i);
            check("nob_eol", 1, 32'(obs1[i].eol), 32'(i == 2 || i == 5));
            check("nob_sof", 1, 32'(obs1[i].sof), 32'(i == 0));
         end
         check("nob_done_at", 1, done_cyc[1], obs1[5].cyc + 1);
      end

      // degenerate width 1x4, one blank cycle
      fill_random(2);
      obs2.delete();
      pulse_start(2, k);
      wait_done(2, 50);
      tick();
      check("w1_npix", 2, obs2.size(), 4);
      if (obs2.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            check("w1_eol", 2, 32'(obs2[i].eol), 1);
            check("w1_sof", 2, 32'(obs2[i].sof), 32'(i == 0));
            if (i > 0) check("w1_spacing", 2, obs2[i].cyc - obs2[i-1].cyc, 2);
         end
         check("w1_done_at", 2, done_cyc[2], obs2[3].cyc + 1);
      end

      // start while busy, including the done cycle
      fill_random(0);
      obs0.delete();
      dc = done_cnt[0];
      pulse_start(0, k);
      repeat (20) tick();
      start[0] = 1'b1; tick(); start[0] = 1'b0;
      repeat (30) tick();
      start[0] = 1'b1; tick(); start[0] = 1'b0;
      wait_done(0, 200);
      start[0] = 1'b1; tick(); start[0] = 1'b0;
      repeat (8) tick();
      check("busy_ignore_done_count", 0, done_cnt[0] - dc, 1);
      check("busy_ignore_npix", 0, obs0.size(), 70);
      check("busy_ignore_idle", 0, 32'(busy[0]), 0);

      // start held high: back-to-back frames
      obs0.delete();
      dc = done_cnt[0];
      start[0] = 1'b1;
      wait_done(0, 200);
      d1 = cyc;
      wait_done(0, 200);
      d2 = cyc;
      start[0] = 1'b0;
      repeat (6) tick();
      check("b2b_period", 0, d2 - d1, 86);
      check("b2b_npix", 0, obs0.size(), 140);
      check("b2b_done_count", 0, done_cnt[0] - dc, 2);

      // reset asserted during the third line
      fill_random(0);
      pulse_start(0, k);
      repeat (28) tick();
      check("pre_rst_valid", 0, 32'(valid[0]), 1);
      check("pre_rst_busy", 0, 32'(busy[0]), 1);
      @(posedge clk);
      #2;
      rst_n[0] = 1'b0;
      #1;
      check("async_rst_valid", 0, 32'(valid[0]), 0);
      check("async_rst_rd_en", 0, 32'(rd_en[0]), 0);
      check("async_rst_busy", 0, 32'(busy[0]), 0);
      check("async_rst_flags", 0, 32'({eol[0], sof[0], done[0]}), 0);
      repeat (2) tick();
      @(posedge clk);
      #2;
      rst_n[0] = 1'b1;
      obs0.delete();
      dc = done_cnt[0];
      repeat (10) tick();
      check("post_rst_silent", 0, obs0.size(), 0);
      check("post_rst_no_done", 0, done_cnt[0] - dc, 0);
      fill_random(0);
      pulse_start(0, k);
      wait_done(0, 200);
      tick();
      check("post_rst_npix", 0, obs0.size(), 70);
      if (obs0.size() > 0) begin
         check("post_rst_sof", 0, 32'(obs0[0].sof), 1);
         check("post_rst_first_data", 0, obs0[0].data, 32'(mem[0][0]));
         check("post_rst_first_valid", 0, obs0[0].cyc - k, 2);
      end

      // randomized frames with stray start activity
      repeat (15) begin
         d = $urandom_range(0, 2);
         fill_random(d);
         hold = ($urandom_range(0, 3) == 0);
         dc = done_cnt[d];
         budget = CW[d] * CH[d] + (CH[d] - 1) * CB[d] + 20;
         pulse_start(d, k);
         ok = 1'b0;
         for (int i = 0; i < budget && !ok; i++) begin
            start[d] = hold ? 1'b1 : ($urandom_range(0, 7) == 0);
            tick();
            if (done[d] === 1'b1) ok = 1'b1;
         end
         start[d] = 1'b0;
         check("rand_done_seen", d, 32'(ok), 1);
         tick();
         check("rand_done_count", d, done_cnt[d] - dc, 1);
         repeat ($urandom_range(0, 3)) tick();
      end

      repeat (5) tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
